// File: rtl/gelato_ram_arbiter.sv
// gelato_ram_arbiter
// Round-robin arbiter sharing one instruction-fetch RAM port among NUM_REQ
// L1 requesters. One transaction is in flight at a time. The RAM request is
// held until ram_done, and the read data is returned with a one-cycle
// one-hot done pulse. rdy=0 freezes all progress. A ram_done that arrives
// during a freeze is parked and consumed when rdy returns.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   rdy                 global enable (0 = freeze)
//   req_valid/req_addr  per-requester request and packed addresses
//   req_done/req_data   one-hot completion pulse and shared return data
//   ram_valid/ram_addr  RAM request
//   ram_done/ram_data   RAM completion pulse and read data
//   busy                state is not IDLE
//   grant_id            current or last grantee
//
// state | meaning
// IDLE  | arbitrate among req_valid, starting after last_grant
// BUSY  | RAM request outstanding, waiting for ram_done or the pending flag
// RESP  | req_done pulse is high for the grantee

module gelato_ram_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rdy,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_done,
   output logic [DATA_WIDTH-1:0]         req_data,
   output logic                          ram_valid,
   output logic [ADDR_WIDTH-1:0]         ram_addr,
   input  logic                          ram_done,
   input  logic [DATA_WIDTH-1:0]         ram_data,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                state, state_nxt;
   logic [GW-1:0]         last_grant, last_nxt;
   logic [GW-1:0]         grant_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic                  rv_nxt;
   logic [NUM_REQ-1:0]    done_nxt;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic                  pend, pend_nxt;
   logic [DATA_WIDTH-1:0] pend_data, pdata_nxt;
   logic                  sel_found;
   logic [GW-1:0]         sel_id;
   logic [GW-1:0]         cand_id;

   // Search upward from last_grant+1 so the previous grantee comes last.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      cand_id   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand_id = GW'((int'(last_grant) + i) % NUM_REQ);
         if (!sel_found && req_valid[cand_id]) begin
            sel_found = 1'b1;
            sel_id    = cand_id;
         end
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= GW'(NUM_REQ - 1);
         grant_id   <= '0;
         ram_addr   <= '0;
         ram_valid  <= 1'b0;
         req_done   <= '0;
         req_data   <= '0;
         pend       <= 1'b0;
         pend_data  <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_nxt;
         grant_id   <= grant_nxt;
         ram_addr   <= addr_nxt;
         ram_valid  <= rv_nxt;
         req_done   <= done_nxt;
         req_data   <= data_nxt;
         pend       <= pend_nxt;
         pend_data  <= pdata_nxt;
         busy       <= (state_nxt != IDLE);
      end
   end

   // Next state
   always_comb begin
      state_nxt = state;
      if (rdy) begin
         case (state)
            IDLE:    if (sel_found) state_nxt = BUSY;
            BUSY:    if (ram_done || pend) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Next values of the registered outputs
   always_comb begin
      last_nxt  = last_grant;
      grant_nxt = grant_id;
      addr_nxt  = ram_addr;
      rv_nxt    = ram_valid;
      done_nxt  = req_done;
      data_nxt  = req_data;
      pend_nxt  = pend;
      pdata_nxt = pend_data;
      if (rdy) begin
         case (state)
            IDLE: begin
               if (sel_found) begin
                  last_nxt  = sel_id;
                  grant_nxt = sel_id;
                  addr_nxt  = req_addr[sel_id*ADDR_WIDTH +: ADDR_WIDTH];
                  rv_nxt    = 1'b1;
               end
            end
            BUSY: begin
               if (ram_done || pend) begin
                  // A parked completion takes precedence over the live bus.
                  data_nxt           = pend ? pend_data : ram_data;
                  done_nxt           = '0;
                  done_nxt[grant_id] = 1'b1;
                  rv_nxt             = 1'b0;
                  pend_nxt           = 1'b0;
               end
            end
            RESP:    done_nxt = '0;
            default: ;
         endcase
      end else if (state == BUSY && ram_done && !pend) begin
         // ram_done is a single pulse and must not be lost while frozen.
         pend_nxt  = 1'b1;
         pdata_nxt = ram_data;
      end
   end

   // ram_done outside BUSY is a RAM-side protocol violation. It is ignored.
   always @(posedge clk) begin
      if (rst_n)
         assert (!(ram_done && state != BUSY))
            else $warning("gelato_ram_arbiter: ram_done outside BUSY ignored");
   end

endmodule

// File: tb/tb_gelato_ram_arbiter.sv
module tb_gelato_ram_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            rdy = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_done;
   logic [DW-1:0]   req_data;
   logic            ram_valid;
   logic [AW-1:0]   ram_addr;
   logic            ram_done = 1'b0;
   logic [DW-1:0]   ram_data = '0;
   logic            busy;
   logic [1:0]      grant_id;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   gelato_ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rdy       (rdy),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_done  (req_done),
      .req_data  (req_data),
      .ram_valid (ram_valid),
      .ram_addr  (ram_addr),
      .ram_done  (ram_done),
      .ram_data  (ram_data),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (ram_valid !== 1'b0) begin errors++; $display("FAIL reset_ram_valid got %h exp 0", ram_valid); end
      checks++; if (req_done !== 4'b0) begin errors++; $display("FAIL reset_req_done got %b exp 0000", req_done); end
      checks++; if (req_data !== 32'h0) begin errors++; $display("FAIL reset_req_data got %h exp 0", req_data); end
      checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL reset_ram_addr got %h exp 0", ram_addr); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      req_valid = 4'b0001;
      tick();
      checks++; if (ram_valid !== 1'b1) begin errors++; $display("FAIL single_ram_valid got %h exp 1", ram_valid); end
      checks++; if (ram_addr !== 32'h100) begin errors++; $display("FAIL single_ram_addr got %h exp 100", ram_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %h exp 1", busy); end
      tick();
      checks++; if (req_done !== 4'b0) begin errors++; $display("FAIL single_early_done got %b exp 0000", req_done); end
      ram_done = 1'b1;
      ram_data = 32'hDEADBEEF;
      tick();
      ram_done = 1'b0;
      req_valid = 4'b0000;
      checks++; if (req_done !== 4'b0001) begin errors++; $display("FAIL single_req_done got %b exp 0001", req_done); end
      checks++; if (req_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_req_data got %h exp deadbeef", req_data); end
      checks++; if (ram_valid !== 1'b0) begin errors++; $display("FAIL single_ram_valid_drop got %h exp 0", ram_valid); end
      tick();
      checks++; if (req_done !== 4'b0) begin errors++; $display("FAIL single_done_clear got %b exp 0000", req_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %h exp 0", busy); end
   endtask

   // Also covers minimum occupancy: ram_done in the first BUSY cycle, grants 3 cycles apart.
   task automatic test_round_robin;
      int rr_exp[5] = '{0, 1, 2, 3, 0};
      int dcnt[4]   = '{0, 0, 0, 0};
      int last_cyc  = 0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (grant_id !== 2'(rr_exp[k])) begin errors++; $display("FAIL rr_grant[%0d] got %0d exp %0d", k, grant_id, rr_exp[k]); end
         checks++; if (ram_addr !== 32'h100 + 32'h40 * 32'(rr_exp[k])) begin errors++; $display("FAIL rr_addr[%0d] got %h exp %h", k, ram_addr, 32'h100 + 32'h40 * 32'(rr_exp[k])); end
         if (k > 0) begin
            checks++; if (cyc - last_cyc != 3) begin errors++; $display("FAIL rr_spacing[%0d] got %0d exp 3", k, cyc - last_cyc); end
         end
         last_cyc = cyc;
         ram_done = 1'b1;
         ram_data = 32'hA000 + 32'(k);
         tick();
         ram_done = 1'b0;
         for (int i = 0; i < N; i++) if (req_done[i]) dcnt[i]++;
         checks++; if (req_done !== 4'(1 << rr_exp[k])) begin errors++; $display("FAIL rr_done[%0d] got %b exp %b", k, req_done, 4'(1 << rr_exp[k])); end
         checks++; if (req_data !== 32'hA000 + 32'(k)) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", k, req_data, 32'hA000 + 32'(k)); end
         if (k == 3) begin
            for (int i = 0; i < N; i++) begin
               checks++; if (dcnt[i] != 1) begin errors++; $display("FAIL rr_round_count[%0d] got %0d exp 1", i, dcnt[i]); end
            end
         end
         req_valid[rr_exp[k]] = 1'b0;
         tick();
         checks++; if (req_done !== 4'b0) begin errors++; $display("FAIL rr_done_clear[%0d] got %b exp 0000", k, req_done); end
         if (k < 4) req_valid[rr_exp[k]] = 1'b1;
         else       req_valid = 4'b0000;
      end
      tick();
   endtask

   task automatic test_fairness;
      int f_exp[3] = '{1, 3, 1};
      req_valid = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (grant_id !== 2'(f_exp[k])) begin errors++; $display("FAIL fair_grant[%0d] got %0d exp %0d", k, grant_id, f_exp[k]); end
         ram_done = 1'b1;
         ram_data = 32'hF000 + 32'(k);
         tick();
         ram_done = 1'b0;
         checks++; if (req_done !== 4'(1 << f_exp[k])) begin errors++; $display("FAIL fair_done[%0d] got %b exp %b", k, req_done, 4'(1 << f_exp[k])); end
         req_valid[f_exp[k]] = 1'b0;
         tick();
         if (k == 0) req_valid = 4'b1010;
      end
      tick();
   endtask

   task automatic test_rdy_stall;
      req_valid = 4'b0100;
      tick();
      checks++; if (grant_id !== 2'd2 || ram_valid !== 1'b1) begin errors++; $display("FAIL stall_grant got id %0d valid %h exp id 2 valid 1", grant_id, ram_valid); end
      rdy = 1'b0;
      ram_done = 1'b1;
      ram_data = 32'h1234;
      tick();
      ram_done = 1'b0;
      ram_data = 32'h0BAD;
      checks++; if (req_done !== 4'b0 || ram_valid !== 1'b1) begin errors++; $display("FAIL stall_frozen got done %b valid %h exp 0000 1", req_done, ram_valid); end
      tick();
      tick();
      checks++; if (req_done !== 4'b0) begin errors++; $display("FAIL stall_still_frozen got %b exp 0000", req_done); end
      rdy = 1'b1;
      tick();
      checks++; if (req_done !== 4'b0100) begin errors++; $display("FAIL stall_done got %b exp 0100", req_done); end
      checks++; if (req_data !== 32'h1234) begin errors++; $display("FAIL stall_data got %h exp 1234", req_data); end
      checks++; if (ram_valid !== 1'b0) begin errors++; $display("FAIL stall_ram_valid got %h exp 0", ram_valid); end
      rdy = 1'b0;
      tick();
      checks++; if (req_done !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL stall_done_hold got %b busy %h exp 0100 1", req_done, busy); end
      rdy = 1'b1;
      req_valid = 4'b0000;
      tick();
      checks++; if (req_done !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_end got %b busy %h exp 0000 0", req_done, busy); end
   endtask

   task automatic test_reset_mid_busy;
      req_valid = 4'b0010;
      tick();
      checks++; if (ram_valid !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL rstb_pre got valid %h id %0d exp 1 1", ram_valid, grant_id); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req_valid = 4'b0000;
      checks++; if (ram_valid !== 1'b0 || busy !== 1'b0 || req_done !== 4'b0) begin errors++; $display("FAIL rstb_ctrl got valid %h busy %h done %b exp 0 0 0000", ram_valid, busy, req_done); end
      checks++; if (req_data !== 32'h0 || ram_addr !== 32'h0 || grant_id !== 2'd0) begin errors++; $display("FAIL rstb_data got data %h addr %h id %0d exp 0 0 0", req_data, ram_addr, grant_id); end
      ram_done = 1'b1;
      ram_data = 32'hFFFF;
      tick();
      ram_done = 1'b0;
      checks++; if (req_done !== 4'b0 || busy !== 1'b0 || req_data !== 32'h0) begin errors++; $display("FAIL rstb_stray got done %b busy %h data %h exp 0000 0 0", req_done, busy, req_data); end
      req_valid = 4'b1011;
      tick();
      checks++; if (grant_id !== 2'd0 || ram_addr !== 32'h100) begin errors++; $display("FAIL rstb_first got id %0d addr %h exp 0 100", grant_id, ram_addr); end
      ram_done = 1'b1;
      ram_data = 32'h55;
      tick();
      ram_done = 1'b0;
      checks++; if (req_done !== 4'b0001 || req_data !== 32'h55) begin errors++; $display("FAIL rstb_done got %b data %h exp 0001 55", req_done, req_data); end
      req_valid = 4'b0000;
      tick();
   endtask

   initial begin
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 32'h100 + 32'h40 * 32'(i);
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_rdy_stall();
      test_reset_mid_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gelato_ram_arbiter.md
# gelato_ram_arbiter

Round-robin arbiter that shares the single instruction-fetch RAM port among `NUM_REQ` L1 requesters (instruction caches of different cores or fetch units). It sits between the L1 caches and the RAM interface. It accepts one request at a time and holds the RAM request stable until RAM signals done. It then returns the captured data to the granted requester with a one-cycle done pulse. `rdy` freezes all progress without losing a RAM completion.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 32: RAM data width.
- `clk`  in  1: clock; the block uses one clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `rdy`  in  1: global enable; 0 freezes FSM, pointer and outputs.
- `req_valid`  in  NUM_REQ: per-requester request; held high until that requester's done pulse.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH: per-requester address; slice i is bits [i*ADDR_WIDTH +: ADDR_WIDTH]; stable while valid.
- `req_done`  out  NUM_REQ: one-hot, one-cycle completion pulse.
- `req_data`  out  DATA_WIDTH: shared return data; meaningful only while any `req_done` bit is high.
- `ram_valid`  out  1: RAM request.
- `ram_addr`  out  ADDR_WIDTH: RAM address.
- `ram_done`  in  1: RAM completion pulse; `ram_data` is valid in the same cycle.
- `ram_data`  in  DATA_WIDTH: RAM read data.
- `busy`  out  1: high in any state other than IDLE.
- `grant_id`  out  $clog2(NUM_REQ): index of the current or last grantee.

## Operation
- The FSM has three states: IDLE, BUSY and RESP. All state updates happen only when `rdy`=1, except capture of `ram_done`, described below.
- IDLE: if any `req_valid` bit is 1, select the first set bit searching upward from `last_grant+1` (mod NUM_REQ).
  - Latch its index into `grant_id` and `last_grant`, and latch its address into `ram_addr`.
  - Set `ram_valid`=1 and go to BUSY.
- BUSY: hold `ram_valid`=1 and `ram_addr` stable.
  - When `ram_done` is seen (directly, or via the pending flag), capture `ram_data` into `req_data`.
  - Set `req_done[grant_id]`=1, set `ram_valid`=0 and go to RESP.
- RESP: clear `req_done` and go to IDLE. Arbitration resumes the next cycle.
- `ram_done` is a pulse. If it arrives while `rdy`=0 in BUSY, store `ram_data` and set a pending flag. BUSY consumes the flag on the first cycle with `rdy`=1.
- `ram_done` arriving in IDLE or RESP is ignored. It is a protocol error and is flagged by a simulation assertion.
- A requester drops `req_valid` on the cycle after its `req_done`. The grantee therefore has the lowest priority at the next arbitration.
- Requests present but not granted stay untouched. There is no starvation: the maximum wait is NUM_REQ-1 transactions.
- Reset (`rst_n`=0 at a clock edge), including mid-transaction:
  - state goes to IDLE; `ram_valid`, `req_done`, `req_data`, `ram_addr`, `grant_id`, `busy` and the pending flag go to 0;
  - `last_grant` goes to NUM_REQ-1, so requester 0 has first priority;
  - the outstanding RAM transaction is abandoned.

## Timing
- All outputs are registered.
- Request sampled high in IDLE at edge E0 gives `ram_valid`=1 starting the cycle after E0.
- `ram_done` sampled at edge Ek gives `req_done` high for exactly the cycle after Ek. The FSM returns to IDLE one cycle later.
- Minimum per-request occupancy is 3 cycles, when `ram_done` arrives in the first BUSY cycle. Back-to-back grants are therefore spaced at least 3 cycles apart.
- `rdy`=0 adds exactly one cycle of delay per frozen cycle. Outputs hold their values while frozen.
  - A `req_done` pulse that is high when `rdy` falls stays high until the first `rdy`=1 edge.
  - Requesters qualify done with `rdy`.

## Test plan
- Single request: `req_valid`=0001 with addr 0x100 and RAM done 2 cycles later with data 0xDEADBEEF. Expect `ram_valid` high with `ram_addr`=0x100, then `req_done`=0001 with `req_data`=0xDEADBEEF for 1 cycle, then `busy`=0.
- Round-robin with all four requesters continuously valid. Expect grant order 0,1,2,3,0 and each `req_done` bit pulsing exactly once per round.
- Fairness after grant: requesters 1 and 3 valid and last grant=1. Expect 3 granted next, then 1.
- `rdy` stall: `ram_done` pulses while `rdy`=0 with data 0x1234, then `rdy` returns to 1 three cycles later. Expect a `req_done` pulse carrying 0x1234 on the first `rdy`=1 cycle, and no lost completion.
- Reset mid-BUSY: assert `rst_n`=0 for 1 cycle while `ram_valid`=1. Expect all outputs 0 next cycle, a later stray `ram_done` ignored, and requester 0 granted first afterward.
- Minimum latency: `ram_done` asserted in the first BUSY cycle. Expect `req_done` on the next cycle and a new grant 3 cycles after the previous one.
